mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets data and address width; only 32 is supported.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 memRead  input  1  load request from controller.
REQ-005 memWrite  input  1  store request from controller.
REQ-006 isByte / isHalf / isWord  input  1 each  access size from controller.
REQ-007 isUnsigned  input  1  zero-extend load (func3[2]).
REQ-008 addr  input  WIDTH  byte address of access.
REQ-009 wdata  input  WIDTH  store data; low bytes used for byte/half.
REQ-010 mem_addr  output  WIDTH  byte address to byte-wide memory.
REQ-011 mem_wdata  output  8  byte to memory.
REQ-012 mem_re  output  1  memory read strobe.
REQ-013 mem_we  output  1  memory write strobe.
REQ-014 mem_rdata  input  8  byte from memory, valid when mem_ready=1.
REQ-015 mem_ready  input  1  memory completes current byte this cycle.
REQ-016 rdata  output  WIDTH  extended load result.
REQ-017 busy  output  1  high while in ACCESS.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  one-cycle pulse with done on a rejected request.

Function
REQ-020 States: IDLE, ACCESS, DONE; all outputs registered.
REQ-021 IDLE: request = memRead|memWrite sampled at clk edge; latch addr, wdata, size, isUnsigned, direction; clear byte index to 0.
REQ-022 Size priority isWord > isHalf > isByte; byte count N = 4 / 2 / 1.
REQ-023 Rejection (go to DONE with err=1, no memory strobe): memRead and memWrite both high; no size flag set; half with addr[0]=1; word with addr[1:0]!=0.
REQ-024 ACCESS: mem_addr = latched addr + index; mem_re = read, mem_we = write; mem_wdata = wdata[8*index+7 : 8*index]; little-endian.
REQ-025 Strobes held constant until mem_ready=1; a memory stall of any length is tolerated.
REQ-026 On mem_ready=1 during a read, mem_rdata stored into byte lane index of internal buffer; index increments.
REQ-027 mem_ready=1 with index = N-1 -> DONE; strobes deasserted in DONE.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; a request present in DONE is ignored, sampled again only in IDLE.
REQ-029 rdata updated only in the transition into DONE of a successful read: byte sign/zero-extends bit 7, half extends bit 15, word unchanged; held otherwise, including across writes and rejections.
REQ-030 Requests while busy or in DONE are ignored; controller holds memRead/memWrite until done.
REQ-031 Latency with mem_ready tied 1: request sampled at edge t -> ACCESS t+1..t+N -> done high during cycle t+N+1.
REQ-032 mem_addr wraps modulo 2^WIDTH; no overflow flag.
REQ-033 busy=1 exactly in ACCESS; err=0 whenever done=0.

Reset
REQ-034 reset=1 at a clock edge -> IDLE, index=0, rdata=0, mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0, busy=0, done=0, err=0.
REQ-035 reset mid-ACCESS aborts immediately; no further strobes; partial read bytes discarded; reset dominates any concurrent request.

Verification
REQ-036 Load word, addr=0x100, mem_ready=1, bytes 0x78,0x56,0x34,0x12 -> mem_addr 0x100..0x103 with mem_re; rdata=0x12345678; done 5 cycles after request edge.
REQ-037 Load byte signed, mem_rdata=0x80 -> rdata=0xFFFFFF80; repeat isUnsigned=1 -> rdata=0x00000080.
REQ-038 Store half, addr=0x202, wdata=0xAABBCCDD -> mem_we with (0x202,0xDD) then (0x203,0xCC); rdata unchanged; done, err=0.
REQ-039 Load word addr=0x101 -> no mem_re, done=1 and err=1 one cycle after request; same for memRead=memWrite=1.
REQ-040 Load half with mem_ready low 3 cycles per byte -> strobes/address stable during stall; done after 8 ACCESS cycles; correct rdata.
REQ-041 reset asserted during second byte of word load -> next cycle all outputs at reset values, no done pulse, new request accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : Serialises byte/half/word loads and stores onto a byte-wide
//             memory port, little-endian, with sign/zero extension of loads
//             and rejection of malformed or misaligned requests.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             isByte,
    input  logic             isHalf,
    input  logic             isWord,
    input  logic             isUnsigned,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    state_t           r_state;
    state_t           w_nextState;

    // Transaction context captured when a request is accepted
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [1:0]       r_size;
    logic             r_isUnsigned;
    logic             r_isRead;
    logic [1:0]       r_index;
    logic [1:0]       r_lastIdx;
    logic [WIDTH-1:0] r_buf;

    // Registered outputs
    logic [WIDTH-1:0] r_memAddr;
    logic [7:0]       r_memWdata;
    logic             r_memRe;
    logic             r_memWe;
    logic [WIDTH-1:0] r_rdata;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Next-cycle control outputs
    logic             w_memReNext;
    logic             w_memWeNext;
    logic             w_busyNext;
    logic             w_doneNext;
    logic             w_errNext;

    // Request decode
    logic             w_req;
    logic             w_reject;
    logic [1:0]       w_size;
    logic [1:0]       w_lastIdx;

    // Datapath helpers
    logic             w_lastByte;
    logic [1:0]       w_nextIdx;
    logic [WIDTH-1:0] w_bufMerged;
    logic [WIDTH-1:0] w_extended;

    // Decode size (word beats half beats byte) and detect illegal requests
    always_comb begin
        w_req     = memRead | memWrite;
        w_size    = c_SIZE_BYTE;
        w_lastIdx = 2'd0;
        if (isWord) begin
            w_size    = c_SIZE_WORD;
            w_lastIdx = 2'd3;
        end else if (isHalf) begin
            w_size    = c_SIZE_HALF;
            w_lastIdx = 2'd1;
        end
        w_reject = (memRead & memWrite)
                 | ~(isByte | isHalf | isWord)
                 | (~isWord & isHalf & addr[0])
                 | (isWord & (addr[1:0] != 2'b00));
    end

    // Merge the incoming byte into its lane and extend the assembled load
    always_comb begin
        w_lastByte  = (r_index == r_lastIdx);
        w_nextIdx   = r_index + 2'd1;
        w_bufMerged = r_buf;
        w_bufMerged[{r_index, 3'b000} +: 8] = mem_rdata;
        case (r_size)
            c_SIZE_BYTE: w_extended = {{(WIDTH-8){~r_isUnsigned & w_bufMerged[7]}},
                                       w_bufMerged[7:0]};
            c_SIZE_HALF: w_extended = {{(WIDTH-16){~r_isUnsigned & w_bufMerged[15]}},
                                       w_bufMerged[15:0]};
            default:     w_extended = w_bufMerged;
        endcase
    end

    // Next-state and next-control-output logic
    always_comb begin
        w_nextState = r_state;
        w_memReNext = 1'b0;
        w_memWeNext = 1'b0;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_reject) begin
                        w_nextState = DONE;
                        w_doneNext  = 1'b1;
                        w_errNext   = 1'b1;
                    end else begin
                        w_nextState = ACCESS;
                        w_busyNext  = 1'b1;
                        w_memReNext = memRead;
                        w_memWeNext = memWrite;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready && w_lastByte) begin
                    w_nextState = DONE;
                    w_doneNext  = 1'b1;
                end else begin
                    w_busyNext  = 1'b1;
                    w_memReNext = r_isRead;
                    w_memWeNext = ~r_isRead;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and control-output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_memRe <= 1'b0;
            r_memWe <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_memRe <= w_memReNext;
            r_memWe <= w_memWeNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
            r_err   <= w_errNext;
        end
    end

    // Datapath: capture request, step through bytes, assemble load result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= c_SIZE_BYTE;
            r_isUnsigned <= 1'b0;
            r_isRead     <= 1'b0;
            r_index      <= 2'd0;
            r_lastIdx    <= 2'd0;
            r_buf        <= '0;
            r_memAddr    <= '0;
            r_memWdata   <= 8'd0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr       <= addr;
                        r_wdata      <= wdata;
                        r_size       <= w_size;
                        r_isUnsigned <= isUnsigned;
                        r_isRead     <= memRead;
                        r_index      <= 2'd0;
                        r_lastIdx    <= w_lastIdx;
                        r_buf        <= '0;
                        if (!w_reject) begin
                            r_memAddr  <= addr;
                            r_memWdata <= wdata[7:0];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (r_isRead) begin
                            r_buf <= w_bufMerged;
                        end
                        if (w_lastByte) begin
                            if (r_isRead) begin
                                r_rdata <= w_extended;
                            end
                        end else begin
                            r_index    <= w_nextIdx;
                            r_memAddr  <= r_addr + WIDTH'(w_nextIdx);
                            r_memWdata <= r_wdata[{w_nextIdx, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign mem_re    = r_memRe;
    assign mem_we    = r_memWe;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Directed table-driven bench for mem_access_unit with a few
//             hand-written multi-cycle sequences (stall, reset mid-access).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic        isByte;
    logic        isHalf;
    logic        isWord;
    logic        isUnsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .isByte     (isByte),
        .isHalf     (isHalf),
        .isWord     (isWord),
        .isUnsigned (isUnsigned),
        .addr       (addr),
        .wdata      (wdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        b;
        logic        h;
        logic        w;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memWord;   // bytes returned by memory, lane i = byte i
        int          nBytes;    // 0 means the request must be rejected
        int          stall;     // mem_ready low cycles before each byte
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic rd, input logic wr, input logic b,
                                input logic h, input logic w, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] mw, input int n, input int st,
                                input logic [31:0] exp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.b = b; v.h = h; v.w = w; v.u = u;
        v.addr = a; v.wdata = wd; v.memWord = mw;
        v.nBytes = n; v.stall = st; v.expRdata = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dropReq();
        memRead = 0; memWrite = 0; isByte = 0; isHalf = 0; isWord = 0; isUnsigned = 0;
    endtask

    // Called at #1 after a rising edge with the DUT idle
    task automatic runVec(input int k, input vec_t v);
        logic [31:0] mw;
        logic [31:0] wd;
        mw = v.memWord;
        wd = v.wdata;
        memRead = v.rd; memWrite = v.wr;
        isByte = v.b; isHalf = v.h; isWord = v.w; isUnsigned = v.u;
        addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        if (v.nBytes == 0) begin
            chk($sformatf("v%0d rej done", k), 32'(done), 32'd1);
            chk($sformatf("v%0d rej err", k), 32'(err), 32'd1);
            chk($sformatf("v%0d rej re", k), 32'(mem_re), 32'd0);
            chk($sformatf("v%0d rej we", k), 32'(mem_we), 32'd0);
            chk($sformatf("v%0d rej busy", k), 32'(busy), 32'd0);
        end else begin
            for (int i = 0; i < v.nBytes; i++) begin
                for (int s = 0; s <= v.stall; s++) begin
                    chk($sformatf("v%0d b%0d s%0d busy", k, i, s), 32'(busy), 32'd1);
                    chk($sformatf("v%0d b%0d s%0d done", k, i, s), 32'(done), 32'd0);
                    chk($sformatf("v%0d b%0d s%0d addr", k, i, s), mem_addr, v.addr + 32'(i));
                    chk($sformatf("v%0d b%0d s%0d re", k, i, s), 32'(mem_re), 32'(v.rd));
                    chk($sformatf("v%0d b%0d s%0d we", k, i, s), 32'(mem_we), 32'(v.wr));
                    if (v.wr)
                        chk($sformatf("v%0d b%0d s%0d wdata", k, i, s), 32'(mem_wdata), 32'(wd[8*i +: 8]));
                    mem_ready = (s == v.stall);
                    mem_rdata = (s == v.stall) ? mw[8*i +: 8] : 8'hEE;
                    @(posedge clk); #1;
                end
            end
            mem_ready = 0;
            mem_rdata = 8'h00;
            chk($sformatf("v%0d done", k), 32'(done), 32'd1);
            chk($sformatf("v%0d err", k), 32'(err), 32'd0);
            chk($sformatf("v%0d busy end", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d re end", k), 32'(mem_re), 32'd0);
            chk($sformatf("v%0d we end", k), 32'(mem_we), 32'd0);
        end
        chk($sformatf("v%0d rdata", k), rdata, v.expRdata);
        // Request still held through DONE: must not start a new access
        @(posedge clk); #1;
        dropReq();
        chk($sformatf("v%0d post done", k), 32'(done), 32'd0);
        chk($sformatf("v%0d post err", k), 32'(err), 32'd0);
        chk($sformatf("v%0d post busy", k), 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d idle busy", k), 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(1,0,0,0,1,0, 32'h100,      32'h0,        32'h12345678, 4,0, 32'h12345678);
        vecs[1]  = mk(1,0,1,0,0,0, 32'h10,       32'h0,        32'h00000080, 1,0, 32'hFFFFFF80);
        vecs[2]  = mk(1,0,1,0,0,1, 32'h10,       32'h0,        32'h00000080, 1,1, 32'h00000080);
        vecs[3]  = mk(0,1,0,1,0,0, 32'h202,      32'hAABBCCDD, 32'h0,        2,0, 32'h00000080);
        vecs[4]  = mk(1,0,0,0,1,0, 32'h101,      32'h0,        32'h0,        0,0, 32'h00000080);
        vecs[5]  = mk(1,1,0,0,1,0, 32'h100,      32'h0,        32'h0,        0,0, 32'h00000080);
        vecs[6]  = mk(1,0,0,0,0,0, 32'h100,      32'h0,        32'h0,        0,0, 32'h00000080);
        vecs[7]  = mk(1,0,0,1,0,0, 32'h203,      32'h0,        32'h0,        0,0, 32'h00000080);
        vecs[8]  = mk(1,0,0,1,0,0, 32'h206,      32'h0,        32'h0000F234, 2,3, 32'hFFFFF234);
        vecs[9]  = mk(1,0,0,1,0,1, 32'h206,      32'h0,        32'h0000F234, 2,0, 32'h0000F234);
        vecs[10] = mk(0,1,0,0,1,0, 32'h300,      32'h11223344, 32'h0,        4,2, 32'h0000F234);
        vecs[11] = mk(0,1,1,0,0,0, 32'h401,      32'h00000099, 32'h0,        1,0, 32'h0000F234);
        vecs[12] = mk(1,0,1,0,1,0, 32'h104,      32'h0,        32'h04030201, 4,1, 32'h04030201);
        vecs[13] = mk(1,0,1,1,0,0, 32'h105,      32'h0,        32'h0,        0,0, 32'h04030201);
        vecs[14] = mk(1,0,0,1,0,0, 32'hFFFFFFFE, 32'h0,        32'h00007F01, 2,0, 32'h00007F01);
        vecs[15] = mk(1,0,1,0,0,0, 32'h7,        32'h0,        32'h0000007F, 1,0, 32'h0000007F);
        vecs[16] = mk(1,0,0,0,1,0, 32'h102,      32'h0,        32'h0,        0,0, 32'h0000007F);
        vecs[17] = mk(0,1,0,0,0,0, 32'h300,      32'h12345678, 32'h0,        0,0, 32'h0000007F);

        reset = 1; dropReq(); addr = 0; wdata = 0; mem_rdata = 0; mem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
        chk("reset re", 32'(mem_re), 32'd0);
        chk("reset we", 32'(mem_we), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 0;
        @(posedge clk); #1;

        for (int k = 0; k < 18; k++) begin
            runVec(k, vecs[k]);
        end

        // Reset in the second byte of a word load, with the request still held
        memRead = 1; isWord = 1; addr = 32'h500; mem_ready = 1; mem_rdata = 8'h11;
        @(posedge clk); #1;
        chk("rst seq busy b0", 32'(busy), 32'd1);
        chk("rst seq addr b0", mem_addr, 32'h500);
        @(posedge clk); #1;
        chk("rst seq addr b1", mem_addr, 32'h501);
        reset = 1;
        @(posedge clk); #1;
        dropReq(); reset = 0; mem_ready = 0;
        chk("rst seq mem_addr", mem_addr, 32'h0);
        chk("rst seq mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst seq re", 32'(mem_re), 32'd0);
        chk("rst seq we", 32'(mem_we), 32'd0);
        chk("rst seq rdata", rdata, 32'h0);
        chk("rst seq busy", 32'(busy), 32'd0);
        chk("rst seq done", 32'(done), 32'd0);
        chk("rst seq err", 32'(err), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst seq quiet done c%0d", c), 32'(done), 32'd0);
            chk($sformatf("rst seq quiet busy c%0d", c), 32'(busy), 32'd0);
        end
        runVec(100, mk(1,0,1,0,0,1, 32'h600, 32'h0, 32'h0000005A, 1,0, 32'h0000005A));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
